// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: recovers pixel coordinates from HSYNC/VSYNC on pix_ce strobes,
// locks onto the expected line/frame timing and checksums the active pixels of each frame.
module vga_sync_receiver #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FRONT     = 11,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 31,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_ce,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    input  logic        clear_err,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        err_hlen,
    output logic        err_vlen,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [23:0] checksum,
    output logic [15:0] frame_count
);

    localparam logic [10:0] H_TOTAL   = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [9:0]  V_TOTAL   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [10:0] H_START   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END     = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END     = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [10:0] HCNT_MAX  = 11'h7FF;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        first_line_q, first_line_d;
    logic [23:0] acc_q, acc_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        err_hlen_q, err_hlen_d, err_vlen_q, err_vlen_d;
    logic [10:0] line_len_q, line_len_d;
    logic [9:0]  frame_lines_q, frame_lines_d;
    logic [23:0] checksum_q, checksum_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic        hs_act, vs_act, hs_edge, vs_edge;
    logic [10:0] line_meas;
    logic        h_bad, h_sat, v_good, checking, set_h, set_v, commit;
    logic        in_active, sample_valid;
    logic [10:0] x_off;
    logic [9:0]  y_off;
    logic [5:0]  pix_sum;

    assign hs_act    = (hsync == SYNC_ACTIVE);
    assign vs_act    = (vsync == SYNC_ACTIVE);
    assign hs_edge   = pix_ce && hs_act && !hs_prev_q;
    assign vs_edge   = pix_ce && vs_act && !vs_prev_q;
    assign hs_prev_d = pix_ce ? hs_act : hs_prev_q;
    assign vs_prev_d = pix_ce ? vs_act : vs_prev_q;

    assign line_meas = hcnt_q + 11'd1;
    assign pix_sum   = {2'b00, rgb[11:8]} + {2'b00, rgb[7:4]} + {2'b00, rgb[3:0]};

    // Counters and the index of the pixel being sampled right now.
    always_comb begin
        hcnt_d = hcnt_q;
        if (hs_edge) begin
            hcnt_d = '0;
        end else if (pix_ce && hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + 11'd1;
        end

        vcnt_d = vcnt_q;
        if (vs_edge) begin
            vcnt_d = '0;
        end else if (hs_edge) begin
            vcnt_d = vcnt_q + 10'd1;
        end

        line_len_d    = hs_edge ? line_meas : line_len_q;
        frame_lines_d = vs_edge ? vcnt_q : frame_lines_q;
    end

    assign in_active = pix_ce && (hcnt_d >= H_START) && (hcnt_d <= H_END) &&
                       (vcnt_d >= V_START) && (vcnt_d <= V_END);
    assign sample_valid = (state_q == ST_LOCKED) && in_active;
    assign x_off = hcnt_d - H_START;
    assign y_off = vcnt_d - V_START;

    // The line straddling the vsync edge that opened ALIGN is partial, so it is not measured.
    assign h_bad    = hs_edge && !first_line_q && (line_meas != H_TOTAL);
    assign h_sat    = pix_ce && !hs_edge && (hcnt_d == HCNT_MAX);
    assign v_good   = (vcnt_q == V_TOTAL);
    assign checking = (state_q == ST_ALIGN) || (state_q == ST_LOCKED);
    assign set_h    = checking && (h_bad || h_sat);
    assign set_v    = checking && vs_edge && !v_good;

    always_comb begin
        state_d      = state_q;
        first_line_d = first_line_q && !hs_edge;
        commit       = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (vs_edge) begin
                    state_d      = ST_ALIGN;
                    first_line_d = 1'b1;
                end
            end
            ST_ALIGN: begin
                if (set_h) begin
                    state_d = ST_SEARCH;
                end else if (vs_edge && v_good) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (set_h || set_v) begin
                    state_d = ST_SEARCH;
                end else if (vs_edge) begin
                    commit = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (vs_edge) begin
            acc_d = '0;
        end else if (sample_valid) begin
            acc_d = acc_q + {18'd0, pix_sum};
        end

        checksum_d    = commit ? acc_q : checksum_q;
        frame_count_d = commit ? frame_count_q + 16'd1 : frame_count_q;

        x_d           = x_q;
        y_d           = y_q;
        pixel_valid_d = pixel_valid_q;
        if (pix_ce) begin
            x_d           = in_active ? x_off[9:0] : 10'd0;
            y_d           = in_active ? y_off : 10'd0;
            pixel_valid_d = sample_valid;
        end
        frame_start_d = vs_edge;

        // A new error in the same cycle as clear_err still sets the flag.
        err_hlen_d = set_h || (err_hlen_q && !clear_err);
        err_vlen_d = set_v || (err_vlen_q && !clear_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_SEARCH;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            first_line_q  <= 1'b0;
            acc_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            err_hlen_q    <= 1'b0;
            err_vlen_q    <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            checksum_q    <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            first_line_q  <= first_line_d;
            acc_q         <= acc_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pixel_valid_q <= pixel_valid_d;
            frame_start_q <= frame_start_d;
            err_hlen_q    <= err_hlen_d;
            err_vlen_q    <= err_vlen_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            checksum_q    <= checksum_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == ST_LOCKED);
    assign err_hlen    = err_hlen_q;
    assign err_vlen    = err_vlen_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign checksum    = checksum_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver, run on a scaled-down 16x12 raster so whole frames
// stay short; each scenario task checks its own expected values.
module tb_vga_sync_receiver;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_ce;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        clear_err;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pixel_valid;
    logic        frame_start;
    logic        locked;
    logic        err_hlen;
    logic        err_vlen;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic [23:0] checksum;
    logic [15:0] frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic        cap_pv_first, cap_pv_last, cap_pv_pre, cap_pv_post;
    logic [9:0]  cap_x_first, cap_y_first, cap_x_last, cap_y_last;
    logic        cap_fs, cap_fs_after;
    logic [10:0] cap_ll6;
    logic [23:0] exp_sum;

    vga_sync_receiver #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .clear_err(clear_err), .x(x), .y(y), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .locked(locked), .err_hlen(err_hlen),
        .err_vlen(err_vlen), .line_len(line_len), .frame_lines(frame_lines),
        .checksum(checksum), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] color(input int mode, input int ln, input int p);
        logic [3:0] a, b;
        a = ln[3:0];
        b = p[3:0];
        case (mode)
            0:       return 12'hFFF;
            1:       return {a, b, a ^ b};
            default: return 12'h123;
        endcase
    endfunction

    // Expected checksum of one full frame drawn in the given colour mode.
    function automatic logic [23:0] frame_sum(input int mode);
        int s;
        logic [11:0] c;
        s = 0;
        for (int ln = VS + VB; ln < VS + VB + VA; ln++) begin
            for (int p = HS + HB; p < HS + HB + HA; p++) begin
                c = color(mode, ln, p);
                s += int'(c[11:8]) + int'(c[7:4]) + int'(c[3:0]);
            end
        end
        return s[23:0];
    endfunction

    // Vsync asserts one pixel after the hsync edge of line 0, so it never coincides with it.
    task automatic drive_frame(input int nlines, input int short_line, input int short_len,
                               input int mode);
        int len;
        for (int ln = 0; ln < nlines; ln++) begin
            len = (ln == short_line) ? short_len : HT;
            for (int p = 0; p < len; p++) begin
                @(negedge clk);
                hsync  = (p < HS) ? 1'b0 : 1'b1;
                vsync  = ((ln == 0 && p >= 1) || (ln > 0 && ln < VS) || (ln == VS && p == 0))
                         ? 1'b0 : 1'b1;
                rgb    = color(mode, ln, p);
                pix_ce = 1'b1;
                @(negedge clk);
                pix_ce = 1'b0;
                if (ln == 0 && p == 1) cap_fs = frame_start;
                if (ln == 0 && p == 2) cap_fs_after = frame_start;
                if (ln == 6 && p == 0) cap_ll6 = line_len;
                if (ln == VS + VB && p == HS + HB - 1) cap_pv_pre = pixel_valid;
                if (ln == VS + VB && p == HS + HB) begin
                    cap_pv_first = pixel_valid;
                    cap_x_first  = x;
                    cap_y_first  = y;
                end
                if (ln == VS + VB + VA - 1 && p == HS + HB + HA - 1) begin
                    cap_pv_last = pixel_valid;
                    cap_x_last  = x;
                    cap_y_last  = y;
                end
                if (ln == VS + VB + VA - 1 && p == HS + HB + HA) cap_pv_post = pixel_valid;
            end
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic test_reset();
        logic [87:0] all_out;
        reset_n = 1'b0; pix_ce = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0; clear_err = 1'b0;
        repeat (3) @(negedge clk);
        all_out = {x, y, pixel_valid, frame_start, locked, err_hlen, err_vlen, line_len,
                   frame_lines, checksum, frame_count};
        n_tests++; if (all_out !== '0) begin n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_out); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        all_out = {x, y, pixel_valid, frame_start, locked, err_hlen, err_vlen, line_len,
                   frame_lines, checksum, frame_count};
        n_tests++; if (all_out !== '0) begin n_fail++;
            $display("FAIL reset_idle_hold: got %h expected 0", all_out); end
        drive_frame(VT, -1, HT, 0);
        drive_frame(VT, -1, HT, 0);
        drive_frame(5, -1, HT, 1);
        n_tests++; if (locked !== 1'b1) begin n_fail++;
            $display("FAIL reset_prelock: got %0d expected 1", locked); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        all_out = {x, y, pixel_valid, frame_start, locked, err_hlen, err_vlen, line_len,
                   frame_lines, checksum, frame_count};
        n_tests++; if (all_out !== '0) begin n_fail++;
            $display("FAIL reset_midstream: got %h expected 0", all_out); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_lock();
        drive_frame(VT, -1, HT, 1);
        n_tests++; if (locked !== 1'b0) begin n_fail++;
            $display("FAIL lock_after_first_vsync: got %0d expected 0", locked); end
        drive_frame(VT, -1, HT, 0);
        n_tests++; if (locked !== 1'b1) begin n_fail++;
            $display("FAIL lock_after_second_vsync: got %0d expected 1", locked); end
        n_tests++; if (line_len !== 11'(HT)) begin n_fail++;
            $display("FAIL lock_line_len: got %0d expected %0d", line_len, HT); end
        n_tests++; if (frame_lines !== 10'(VT)) begin n_fail++;
            $display("FAIL lock_frame_lines: got %0d expected %0d", frame_lines, VT); end
        n_tests++; if ({err_hlen, err_vlen} !== 2'b00) begin n_fail++;
            $display("FAIL lock_no_errors: got %b expected 00", {err_hlen, err_vlen}); end
        n_tests++; if (frame_count !== 16'd0) begin n_fail++;
            $display("FAIL lock_frame_count: got %0d expected 0", frame_count); end
        n_tests++; if ({cap_fs, cap_fs_after} !== 2'b10) begin n_fail++;
            $display("FAIL frame_start_pulse: got %b expected 10", {cap_fs, cap_fs_after}); end
    endtask

    task automatic test_checksum();
        drive_frame(VT, -1, HT, 2);
        n_tests++; if (checksum !== 24'd2160) begin n_fail++;
            $display("FAIL checksum_white: got %0d expected 2160", checksum); end
        n_tests++; if (frame_count !== 16'd1) begin n_fail++;
            $display("FAIL checksum_count1: got %0d expected 1", frame_count); end
        drive_frame(VT, -1, HT, 1);
        n_tests++; if (checksum !== 24'd288) begin n_fail++;
            $display("FAIL checksum_const123: got %0d expected 288", checksum); end
        n_tests++; if (frame_count !== 16'd2) begin n_fail++;
            $display("FAIL checksum_count2: got %0d expected 2", frame_count); end
    endtask

    task automatic test_coords();
        drive_frame(VT, -1, HT, 0);
        n_tests++; if ({cap_pv_first, cap_x_first, cap_y_first} !== {1'b1, 10'd0, 10'd0}) begin
            n_fail++; $display("FAIL coord_first: got pv=%0d x=%0d y=%0d expected 1 0 0",
                               cap_pv_first, cap_x_first, cap_y_first); end
        n_tests++; if ({cap_pv_last, cap_x_last, cap_y_last} !==
                       {1'b1, 10'(HA - 1), 10'(VA - 1)}) begin
            n_fail++; $display("FAIL coord_last: got pv=%0d x=%0d y=%0d expected 1 %0d %0d",
                               cap_pv_last, cap_x_last, cap_y_last, HA - 1, VA - 1); end
        n_tests++; if ({cap_pv_pre, cap_pv_post} !== 2'b00) begin n_fail++;
            $display("FAIL coord_outside_valid: got %b expected 00", {cap_pv_pre, cap_pv_post});
        end
        exp_sum = frame_sum(1);
        n_tests++; if (checksum !== exp_sum) begin n_fail++;
            $display("FAIL checksum_pattern: got %0d expected %0d", checksum, exp_sum); end
        n_tests++; if (frame_count !== 16'd3) begin n_fail++;
            $display("FAIL checksum_count3: got %0d expected 3", frame_count); end
    endtask

    task automatic test_short_line();
        drive_frame(VT, 5, HT - 1, 0);
        n_tests++; if (cap_ll6 !== 11'(HT - 1)) begin n_fail++;
            $display("FAIL short_line_len: got %0d expected %0d", cap_ll6, HT - 1); end
        n_tests++; if ({err_hlen, locked} !== 2'b10) begin n_fail++;
            $display("FAIL short_line_err: got err_hlen,locked=%b expected 10",
                     {err_hlen, locked}); end
        n_tests++; if (frame_count !== 16'd4 || checksum !== 24'd2160) begin n_fail++;
            $display("FAIL short_line_commit: got count=%0d sum=%0d expected 4 2160",
                     frame_count, checksum); end
        pulse_clear();
        n_tests++; if (err_hlen !== 1'b0) begin n_fail++;
            $display("FAIL clear_err_hlen: got %0d expected 0", err_hlen); end
        drive_frame(VT, -1, HT, 0);
        n_tests++; if (locked !== 1'b0) begin n_fail++;
            $display("FAIL relock_one_vsync: got %0d expected 0", locked); end
        drive_frame(VT, -1, HT, 2);
        n_tests++; if ({locked, err_hlen, err_vlen} !== 3'b100) begin n_fail++;
            $display("FAIL relock_two_vsync: got %b expected 100",
                     {locked, err_hlen, err_vlen}); end
        n_tests++; if (frame_count !== 16'd4) begin n_fail++;
            $display("FAIL relock_count_hold: got %0d expected 4", frame_count); end
    endtask

    task automatic test_short_frame();
        drive_frame(VT - 1, -1, HT, 1);
        drive_frame(VT, -1, HT, 0);
        n_tests++; if ({err_vlen, locked, err_hlen} !== 3'b100) begin n_fail++;
            $display("FAIL short_frame_err: got err_vlen,locked,err_hlen=%b expected 100",
                     {err_vlen, locked, err_hlen}); end
        n_tests++; if (frame_lines !== 10'(VT - 1)) begin n_fail++;
            $display("FAIL short_frame_lines: got %0d expected %0d", frame_lines, VT - 1); end
        n_tests++; if (frame_count !== 16'd5 || checksum !== 24'd288) begin n_fail++;
            $display("FAIL short_frame_hold: got count=%0d sum=%0d expected 5 288",
                     frame_count, checksum); end
        pulse_clear();
        n_tests++; if (err_vlen !== 1'b0) begin n_fail++;
            $display("FAIL clear_err_vlen: got %0d expected 0", err_vlen); end
    endtask

    task automatic test_saturation();
        drive_frame(VT, -1, HT, 0);
        drive_frame(VT, -1, HT, 0);
        n_tests++; if (locked !== 1'b1) begin n_fail++;
            $display("FAIL sat_prelock: got %0d expected 1", locked); end
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            hsync  = 1'b1;
            vsync  = 1'b1;
            pix_ce = 1'b1;
            @(negedge clk);
            pix_ce = 1'b0;
        end
        n_tests++; if ({err_hlen, locked, err_vlen} !== 3'b100) begin n_fail++;
            $display("FAIL sat_err: got err_hlen,locked,err_vlen=%b expected 100",
                     {err_hlen, locked, err_vlen}); end
        n_tests++; if (frame_count !== 16'd5) begin n_fail++;
            $display("FAIL sat_count_hold: got %0d expected 5", frame_count); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_checksum();
        test_coords();
        test_short_line();
        test_short_frame();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
